// File: rtl/vscale_retire_trace_buf.sv
// vscale_retire_trace_buf: retire-trace FIFO for the integer and FP retire ports.
// Each cycle it can capture one integer and one FP record, with the integer
// record first, and it drains them through a valid/ready port. Records that
// find no room are counted in a saturating drop counter.
// Optional feature: define VSCALE_TRACE_TSTAMP_EN to add a free-running
// timestamp that is stored with each record. Without it, out_ts reads 0.
module vscale_retire_trace_buf #(
   parameter int DEPTH    = 8,
   parameter int XLEN     = 32,
   parameter int TS_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    trace_en,
   input  logic                    int_valid,
   input  logic                    int_exc,
   input  logic                    int_wr,
   input  logic [XLEN-1:0]         int_pc,
   input  logic [XLEN-1:0]         int_inst,
   input  logic [XLEN-1:0]         int_data,
   input  logic [4:0]              int_rd,
   input  logic                    fp_valid,
   input  logic [XLEN-1:0]         fp_pc,
   input  logic [XLEN-1:0]         fp_inst,
   input  logic [XLEN-1:0]         fp_data,
   input  logic [4:0]              fp_rd,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [1:0]              out_kind,
   output logic [XLEN-1:0]         out_pc,
   output logic [XLEN-1:0]         out_inst,
   output logic [XLEN-1:0]         out_data,
   output logic [4:0]              out_rd,
   output logic [TS_WIDTH-1:0]     out_ts,
   output logic [$clog2(DEPTH):0]  level,
   output logic [15:0]             drop_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   typedef struct packed {
      logic [1:0]      kind;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] data;
      logic [4:0]      rd;
   } rec_t;

   rec_t          mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fp_slot;
   logic [LW-1:0] level_q, level_d, free;
   logic [15:0]   drop_q, drop_d;
   logic [16:0]   drop_sum;
   logic          int_req, fp_req, push_int, push_fp, pop;
   logic [1:0]    n_push, n_drop;
   rec_t          int_rec, fp_rec, head;

   // Build the records. Exceptions and non-writing instructions report rd as 0.
   always_comb begin
      int_rec.kind = int_exc ? 2'd3 : (int_wr ? 2'd0 : 2'd1);
      int_rec.pc   = int_pc;
      int_rec.inst = int_inst;
      int_rec.data = int_data;
      int_rec.rd   = (!int_exc && int_wr) ? int_rd : 5'd0;
      fp_rec.kind  = 2'd2;
      fp_rec.pc    = fp_pc;
      fp_rec.inst  = fp_inst;
      fp_rec.data  = fp_data;
      fp_rec.rd    = fp_rd;
   end

   // Decide pushes and drops. Room is judged from the registered level only,
   // so a pop in the same cycle does not make room for that cycle's pushes.
   always_comb begin
      int_req  = trace_en & int_valid;
      fp_req   = trace_en & fp_valid;
      free     = LW'(DEPTH) - level_q;
      push_int = 1'b0;
      push_fp  = 1'b0;
      if (free >= LW'(2)) begin
         push_int = int_req;
         push_fp  = fp_req;
      end else if (free == LW'(1)) begin
         push_int = int_req;
         push_fp  = fp_req & ~int_req;
      end
      n_push   = {1'b0, push_int} + {1'b0, push_fp};
      n_drop   = {1'b0, int_req & ~push_int} + {1'b0, fp_req & ~push_fp};
      pop      = out_valid & out_ready;
      fp_slot  = push_int ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
      wr_ptr_d = wr_ptr_q + PW'(n_push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      level_d  = level_q + LW'(n_push) - LW'(pop);
      drop_sum = {1'b0, drop_q} + 17'(n_drop);
      drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   // Pointer, level and drop-counter registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         drop_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         drop_q   <= drop_d;
      end
   end

   // Record storage is not reset. Writes are blocked while reset is held.
   always_ff @(posedge clk) begin
      if (reset && push_int) mem_q[wr_ptr_q] <= int_rec;
      if (reset && push_fp)  mem_q[fp_slot]  <= fp_rec;
   end

`ifdef VSCALE_TRACE_TSTAMP_EN
   logic [TS_WIDTH-1:0] ts_q;
   logic [TS_WIDTH-1:0] ts_mem_q [DEPTH];

   // Free-running timestamp that restarts at 0 on reset.
   always_ff @(posedge clk) begin
      if (!reset) ts_q <= '0;
      else        ts_q <= ts_q + TS_WIDTH'(1);
   end

   // Store the push-cycle timestamp alongside each record.
   always_ff @(posedge clk) begin
      if (reset && push_int) ts_mem_q[wr_ptr_q] <= ts_q;
      if (reset && push_fp)  ts_mem_q[fp_slot]  <= ts_q;
   end

   assign out_ts = out_valid ? ts_mem_q[rd_ptr_q] : '0;
`else
   assign out_ts = '0;
`endif

   assign head       = mem_q[rd_ptr_q];
   assign out_valid  = (level_q != '0);
   assign out_kind   = out_valid ? head.kind : '0;
   assign out_pc     = out_valid ? head.pc   : '0;
   assign out_inst   = out_valid ? head.inst : '0;
   assign out_data   = out_valid ? head.data : '0;
   assign out_rd     = out_valid ? head.rd   : '0;
   assign level      = level_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_vscale_retire_trace_buf.sv
// Testbench for vscale_retire_trace_buf. It runs directed scenarios, a
// drop-counter saturation run and a randomized phase, and compares the design
// against a queue-based model of the trace buffer.
module tb_vscale_retire_trace_buf;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset, trace_en, int_valid, int_exc, int_wr, fp_valid, out_ready;
   logic [31:0] int_pc, int_inst, int_data, fp_pc, fp_inst, fp_data;
   logic [4:0]  int_rd, fp_rd;
   logic        out_valid;
   logic [1:0]  out_kind;
   logic [31:0] out_pc, out_inst, out_data;
   logic [4:0]  out_rd;
   logic [15:0] out_ts, drop_count;
   logic [3:0]  level;

   vscale_retire_trace_buf #(.DEPTH(DEPTH), .XLEN(32), .TS_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .trace_en(trace_en),
      .int_valid(int_valid), .int_exc(int_exc), .int_wr(int_wr),
      .int_pc(int_pc), .int_inst(int_inst), .int_data(int_data), .int_rd(int_rd),
      .fp_valid(fp_valid), .fp_pc(fp_pc), .fp_inst(fp_inst), .fp_data(fp_data),
      .fp_rd(fp_rd), .out_valid(out_valid), .out_ready(out_ready),
      .out_kind(out_kind), .out_pc(out_pc), .out_inst(out_inst),
      .out_data(out_data), .out_rd(out_rd), .out_ts(out_ts),
      .level(level), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  kind;
      logic [31:0] pc, inst, data;
      logic [4:0]  rd;
      logic [15:0] ts;
   } mrec_t;

   mrec_t       q[$];
   int          drops;
   logic [15:0] tscnt;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      mrec_t h;
      logic [15:0] ets;
      h = '{kind: 2'd0, pc: 32'd0, inst: 32'd0, data: 32'd0, rd: 5'd0, ts: 16'd0};
      if (q.size() != 0) h = q[0];
`ifdef VSCALE_TRACE_TSTAMP_EN
      ets = h.ts;
`else
      ets = 16'd0;
`endif
      chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
      chk("level", 128'(level), 128'(q.size()));
      chk("drop_count", 128'(drop_count), 128'(drops));
      chk("head", 128'({out_kind, out_pc, out_inst, out_data, out_rd}),
          128'({h.kind, h.pc, h.inst, h.data, h.rd}));
      chk("out_ts", 128'(out_ts), 128'(ets));
   endtask

   // Advance one clock: update the model from the current inputs, then check.
   task automatic tick();
      mrec_t r;
      int free;
      if (!reset) begin
         q.delete();
         drops = 0;
         tscnt = 16'd0;
      end else begin
         free = DEPTH - q.size();
         if (q.size() != 0 && out_ready) void'(q.pop_front());
         if (trace_en && int_valid) begin
            r.kind = int_exc ? 2'd3 : (int_wr ? 2'd0 : 2'd1);
            r.pc = int_pc; r.inst = int_inst; r.data = int_data;
            r.rd = (r.kind == 2'd0) ? int_rd : 5'd0;
            r.ts = tscnt;
            if (free > 0) begin q.push_back(r); free--; end
            else if (drops < 65535) drops++;
         end
         if (trace_en && fp_valid) begin
            r.kind = 2'd2; r.pc = fp_pc; r.inst = fp_inst; r.data = fp_data;
            r.rd = fp_rd; r.ts = tscnt;
            if (free > 0) begin q.push_back(r); free--; end
            else if (drops < 65535) drops++;
         end
         tscnt = tscnt + 16'd1;
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic idle();
      int_valid = 1'b0; fp_valid = 1'b0; int_exc = 1'b0; int_wr = 1'b0;
   endtask

   task automatic int_in(input logic [31:0] pc, input logic [31:0] data,
                         input logic [4:0] rd, input logic wr, input logic exc);
      int_valid = 1'b1; int_pc = pc; int_inst = pc ^ 32'h0000_0013;
      int_data = data; int_rd = rd; int_wr = wr; int_exc = exc;
   endtask

   task automatic fp_in(input logic [31:0] pc, input logic [31:0] data, input logic [4:0] rd);
      fp_valid = 1'b1; fp_pc = pc; fp_inst = pc ^ 32'h0000_0053; fp_data = data; fp_rd = rd;
   endtask

   task automatic drain();
      idle();
      out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() != 0; i++) tick();
   endtask

   initial begin
      drops = 0; tscnt = 16'd0;
      reset = 1'b0; trace_en = 1'b0; out_ready = 1'b0;
      int_pc = '0; int_inst = '0; int_data = '0; int_rd = '0;
      fp_pc = '0; fp_inst = '0; fp_data = '0; fp_rd = '0;
      idle();
      tick(); tick();
      chk("reset_valid", 128'(out_valid), 128'(0));
      chk("reset_level", 128'(level), 128'(0));

      // Single integer retire, then drained.
      reset = 1'b1; trace_en = 1'b1; out_ready = 1'b1;
      int_in(32'h200, 32'h1234, 5'd5, 1'b1, 1'b0);
      tick(); idle();
      chk("single_valid", 128'(out_valid), 128'(1));
      chk("single_rec", 128'({out_kind, out_rd, out_data, out_pc}),
          128'({2'd0, 5'd5, 32'h1234, 32'h200}));
      tick();
      chk("single_level", 128'(level), 128'(0));

      // Dual retire in one cycle: the integer record drains first.
      out_ready = 1'b0;
      int_in(32'h10, 32'hAA, 5'd1, 1'b1, 1'b0);
      fp_in(32'h14, 32'hBB, 5'd3);
      tick(); idle();
      chk("dual_first", 128'({out_pc, out_kind}), 128'({32'h10, 2'd0}));
      tick();
      chk("dual_hold", 128'({out_pc, out_kind}), 128'({32'h10, 2'd0}));
      out_ready = 1'b1;
      tick();
      chk("dual_second", 128'({out_pc, out_kind, out_rd}), 128'({32'h14, 2'd2, 5'd3}));
      drain();

      // Fill to full, then overflow by one dual retire.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         int_in(32'h100 + 32'(8 * i), 32'(i), 5'(i + 1), 1'b1, 1'b0);
         fp_in(32'h104 + 32'(8 * i), 32'(i + 100), 5'(i + 9));
         tick();
      end
      chk("full_level", 128'(level), 128'(8));
      chk("full_drops", 128'(drop_count), 128'(0));
      tick();
      chk("ovf_level", 128'(level), 128'(8));
      chk("ovf_drops", 128'(drop_count), 128'(2));
      drain();

      // One free slot with a concurrent pop: integer kept, FP dropped.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         int_in(32'h300 + 32'(8 * i), 32'(i), 5'd7, 1'b0, 1'b0);
         fp_in(32'h304 + 32'(8 * i), 32'(i), 5'd8);
         tick();
      end
      idle(); int_in(32'h330, 32'h5, 5'd2, 1'b1, 1'b0);
      tick();
      chk("seven_level", 128'(level), 128'(7));
      int_in(32'h340, 32'h6, 5'd4, 1'b1, 1'b0); fp_in(32'h344, 32'h7, 5'd6);
      out_ready = 1'b1;
      tick();
      chk("one_free_level", 128'(level), 128'(7));
      chk("one_free_drops", 128'(drop_count), 128'(3));
      drain();

      // Exception record carries the ecode in data and reports rd as 0.
      int_in(32'h400, 32'h2, 5'd9, 1'b1, 1'b1);
      tick(); idle();
      chk("exc_rec", 128'({out_kind, out_rd, out_data}), 128'({2'd3, 5'd0, 32'h2}));
      drain();

      // Reset in the middle of a drain with level 5.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         int_in(32'h500 + 32'(8 * i), 32'(i), 5'd1, 1'b1, 1'b0);
         fp_in(32'h504 + 32'(8 * i), 32'(i), 5'd2);
         tick();
      end
      idle(); out_ready = 1'b1;
      tick();
      chk("pre_reset_level", 128'(level), 128'(5));
      reset = 1'b0; int_in(32'h600, 32'h1, 5'd1, 1'b1, 1'b0);
      tick();
      chk("mid_reset", 128'({level, out_valid, drop_count}), 128'({4'd0, 1'b0, 16'd0}));
      reset = 1'b1; idle();
      tick();

`ifdef VSCALE_TRACE_TSTAMP_EN
      reset = 1'b0; tick(); reset = 1'b1;
      tick(); tick(); tick();
      int_in(32'h700, 32'h1, 5'd1, 1'b1, 1'b0);
      tick(); idle();
      chk("ts_3", 128'(out_ts), 128'(3));
      drain();
      while (tscnt != 16'd2) tick();
      int_in(32'h704, 32'h2, 5'd1, 1'b1, 1'b0);
      tick(); idle();
      chk("ts_wrap", 128'(out_ts), 128'(2));
      drain();
`endif

      // Keep the buffer full under dual retires until drop_count saturates.
      out_ready = 1'b0;
      int_in(32'h800, 32'h1, 5'd1, 1'b1, 1'b0); fp_in(32'h804, 32'h2, 5'd2);
      for (int i = 0; i < 32780; i++) tick();
      chk("drop_sat", 128'(drop_count), 128'(16'hFFFF));
      trace_en = 1'b0;
      tick();
      chk("trace_off_drops", 128'(drop_count), 128'(16'hFFFF));
      drain();

      // Randomized phase.
      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(0, 299) != 0);
         trace_en  = ($urandom_range(0, 7) != 0);
         out_ready = ((i / 60) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                         : ($urandom_range(0, 3) == 0);
         int_valid = $urandom_range(0, 1) == 1;
         int_exc   = $urandom_range(0, 7) == 0;
         int_wr    = $urandom_range(0, 1) == 1;
         int_pc = $urandom; int_inst = $urandom; int_data = $urandom; int_rd = 5'($urandom);
         fp_valid  = $urandom_range(0, 1) == 1;
         fp_pc = $urandom; fp_inst = $urandom; fp_data = $urandom; fp_rd = 5'($urandom);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vscale_retire_trace_buf.md
VSCALE_RETIRE_TRACE_BUF -- requirements
Module: vscale_retire_trace_buf

Interface
REQ-001 Parameters: DEPTH, 8, FIFO entries (power of 2, >=4); XLEN, 32, datapath width; TS_WIDTH, 16, timestamp width.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  reset, synchronous, active-low.
REQ-004 trace_en  in  1  capture enable; when 0, channel inputs are ignored.
REQ-005 int_valid  in  1  integer-pipe retire this cycle.
REQ-006 int_exc  in  1  retiring instruction raised an exception.
REQ-007 int_wr  in  1  integer register write (rd != 0).
REQ-008 int_pc, int_inst, int_data  in  XLEN each  integer retire PC, instruction, writeback data; int_data carries ecode (zero-extended) when int_exc=1.
REQ-009 int_rd  in  5  integer destination.
REQ-010 fp_valid  in  1  FP-writeback retire this cycle.
REQ-011 fp_pc, fp_inst, fp_data  in  XLEN each; fp_rd  in  5  FP retire record.
REQ-012 out_valid  out  1; out_ready  in  1  drain handshake.
REQ-013 out_kind  out  2  0=int write, 1=int no-write, 2=fp write, 3=exception.
REQ-014 out_pc, out_inst, out_data  out  XLEN; out_rd  out  5; out_ts  out  TS_WIDTH  head entry fields.
REQ-015 level  out  clog2(DEPTH)+1  occupied entries; drop_count  out  16  dropped records.

Function
REQ-016 Record kind: int_exc=1 -> 3; else int_wr=1 -> 0; else 1; fp record -> 2; kind 1/3 store out_rd=0.
REQ-017 Up to two pushes per cycle when trace_en=1: int record first, fp record second, so int precedes fp in drain order.
REQ-018 Free slots = DEPTH - level (registered value); a pop in the same cycle does not create room for that cycle's pushes.
REQ-019 Free>=2: both records written; free=1: int written, fp dropped (fp alone written if no int); free=0: all dropped.
REQ-020 Each dropped record increments drop_count by 1 (2 if both dropped); drop_count saturates at 16'hFFFF.
REQ-021 Pop occurs when out_valid=1 and out_ready=1; head advances next cycle.
REQ-022 out_valid = (level != 0); output fields combinationally show head entry and read 0 when out_valid=0.
REQ-023 level next = level + pushes - pop; pointers wrap modulo DEPTH.
REQ-024 Push-to-out_valid latency 1 cycle; record pushed into empty buffer appears at outputs the following cycle.
REQ-025 Held out_ready=0 keeps all output fields stable while out_valid=1.
REQ-026 trace_en=0 suppresses pushes and drop counting; draining continues.

Reset
REQ-027 reset=0 at a clock edge clears pointers, level=0, out_valid=0, drop_count=0, timestamp counter=0; storage contents are not reset.
REQ-028 Reset mid-operation discards all buffered records; inputs during reset are ignored.

Configuration
REQ-029 Macro VSCALE_TRACE_TSTAMP_EN defined: free-running TS_WIDTH counter, +1 per cycle from reset, wraps to 0; each record stores counter value at push cycle; out_ts shows it.
REQ-030 Macro undefined: no counter or timestamp storage; out_ts tied to 0.

Verification
REQ-031 Single int retire pc=0x200, rd=5, data=0x1234, out_ready=1 -> next cycle out_valid=1, kind=0, rd=5, data=0x1234; following cycle level=0.
REQ-032 Same cycle int (pc=0x10) and fp (pc=0x14, rd=3) -> drain order pc 0x10 kind 0, then pc 0x14 kind 2 rd 3.
REQ-033 DEPTH=8, out_ready=0, 4 cycles of dual retire -> level=8, drop_count=0; one more dual -> drop_count=2, level=8.
REQ-034 level=7, dual retire with concurrent pop -> int stored, fp dropped, level=7, drop_count=+1.
REQ-035 int_exc=1, ecode 2 -> kind=3, rd=0, data=0x2; reset=0 mid-drain with level=5 -> level=0, out_valid=0, drop_count=0.
REQ-036 With VSCALE_TRACE_TSTAMP_EN, push at cycle 3 and 65538 after reset (TS_WIDTH=16) -> out_ts 3 and 2; without macro out_ts=0.
